// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf
// Pipeline stage register with a valid/ready handshake and a two-entry skid
// buffer (main entry drives the outputs, skid entry absorbs one beat of
// backpressure). Flush turns every held beat into a bubble (IR = NOP_IR,
// control = 0). Saturating counters record stall and flush events.
//
// Ports:
//   clk, rst (async active-low)
//   in_valid / in_ready / in_pc / in_ir / in_ctrl / in_data : upstream side
//   flush                                                  : kill held beats
//   out_valid / out_ready / out_pc / out_ir / out_ctrl / out_data : downstream
//   stall_cnt : cycles with out_valid=1 and out_ready=0 (saturating)
//   flush_cnt : flush cycles that killed a valid entry (saturating)
module pipe_stage_buf #(
    parameter int               PC_W   = 32,
    parameter int               IR_W   = 32,
    parameter int               CTRL_W = 16,
    parameter int               DATA_W = 128,
    parameter logic [IR_W-1:0]  NOP_IR = 32'h00000013,
    parameter int               CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [IR_W-1:0]   in_ir,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [IR_W-1:0]   out_ir,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic              en);
        logic [CNT_W-1:0] r;
        if (en && (v != {CNT_W{1'b1}})) begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    logic              main_v_r;
    logic              skid_v_r;
    logic              in_ready_r;
    logic [PC_W-1:0]   main_pc_r;
    logic [IR_W-1:0]   main_ir_r;
    logic [CTRL_W-1:0] main_ctrl_r;
    logic [DATA_W-1:0] main_data_r;
    logic [PC_W-1:0]   skid_pc_r;
    logic [IR_W-1:0]   skid_ir_r;
    logic [CTRL_W-1:0] skid_ctrl_r;
    logic [DATA_W-1:0] skid_data_r;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic [CNT_W-1:0]  flush_cnt_r;

    logic in_fire_s;
    logic out_fire_s;
    logic main_v_n_s;
    logic skid_v_n_s;
    logic ld_main_in_s;
    logic ld_main_skid_s;
    logic ld_skid_s;

    // in_ready is a register mirroring !skid_v, so no out_ready->in_ready path.
    assign in_fire_s  = in_valid & in_ready_r;
    assign out_fire_s = main_v_r & out_ready;

    // Next-state and load-enable decode for the {main_v, skid_v} occupancy.
    always_comb begin
        main_v_n_s     = main_v_r;
        skid_v_n_s     = skid_v_r;
        ld_main_in_s   = 1'b0;
        ld_main_skid_s = 1'b0;
        ld_skid_s      = 1'b0;
        if (flush) begin
            // Any beat accepted this cycle is consumed and dropped.
            main_v_n_s = 1'b0;
            skid_v_n_s = 1'b0;
        end else begin
            case ({main_v_r, skid_v_r})
                2'b00: begin
                    if (in_fire_s) begin
                        main_v_n_s   = 1'b1;
                        ld_main_in_s = 1'b1;
                    end else begin
                        main_v_n_s = 1'b0;
                    end
                end
                2'b10: begin
                    if (in_fire_s && out_fire_s) begin
                        ld_main_in_s = 1'b1;
                    end else if (in_fire_s) begin
                        skid_v_n_s = 1'b1;
                        ld_skid_s  = 1'b1;
                    end else if (out_fire_s) begin
                        main_v_n_s = 1'b0;
                    end else begin
                        main_v_n_s = 1'b1;
                    end
                end
                2'b11: begin
                    if (out_fire_s) begin
                        ld_main_skid_s = 1'b1;
                        skid_v_n_s     = 1'b0;
                    end else begin
                        skid_v_n_s = 1'b1;
                    end
                end
                default: begin
                    // Skid-only is unreachable; fall back to empty.
                    main_v_n_s = 1'b0;
                    skid_v_n_s = 1'b0;
                end
            endcase
        end
    end

    // Occupancy, ready and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_v_r    <= 1'b0;
            skid_v_r    <= 1'b0;
            in_ready_r  <= 1'b1;
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            main_v_r    <= main_v_n_s;
            skid_v_r    <= skid_v_n_s;
            in_ready_r  <= ~skid_v_n_s;
            stall_cnt_r <= sat_inc(stall_cnt_r, main_v_r & ~out_ready);
            flush_cnt_r <= sat_inc(flush_cnt_r, flush & (main_v_r | skid_v_r));
        end
    end

    // Main entry payload; an empty main always carries a bubble IR/ctrl.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_pc_r   <= {PC_W{1'b0}};
            main_ir_r   <= NOP_IR;
            main_ctrl_r <= {CTRL_W{1'b0}};
            main_data_r <= {DATA_W{1'b0}};
        end else begin
            if (ld_main_in_s) begin
                main_pc_r   <= in_pc;
                main_ir_r   <= in_ir;
                main_ctrl_r <= in_ctrl;
                main_data_r <= in_data;
            end else if (ld_main_skid_s) begin
                main_pc_r   <= skid_pc_r;
                main_ir_r   <= skid_ir_r;
                main_ctrl_r <= skid_ctrl_r;
                main_data_r <= skid_data_r;
            end else begin
                main_pc_r   <= main_pc_r;
                main_ir_r   <= main_ir_r;
                main_ctrl_r <= main_ctrl_r;
                main_data_r <= main_data_r;
            end
            // pc/data keep their last value in a bubble; only IR/ctrl are scrubbed.
            if (!main_v_n_s) begin
                main_ir_r   <= NOP_IR;
                main_ctrl_r <= {CTRL_W{1'b0}};
            end
        end
    end

    // Skid entry payload.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_pc_r   <= {PC_W{1'b0}};
            skid_ir_r   <= NOP_IR;
            skid_ctrl_r <= {CTRL_W{1'b0}};
            skid_data_r <= {DATA_W{1'b0}};
        end else if (ld_skid_s) begin
            skid_pc_r   <= in_pc;
            skid_ir_r   <= in_ir;
            skid_ctrl_r <= in_ctrl;
            skid_data_r <= in_data;
        end else begin
            skid_pc_r   <= skid_pc_r;
            skid_ir_r   <= skid_ir_r;
            skid_ctrl_r <= skid_ctrl_r;
            skid_data_r <= skid_data_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = main_v_r;
    assign out_pc    = main_pc_r;
    assign out_ir    = main_ir_r;
    assign out_ctrl  = main_ctrl_r;
    assign out_data  = main_data_r;
    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Testbench for pipe_stage_buf: directed scenarios followed by random traffic.
// A negedge monitor keeps a FIFO reference model of accepted beats plus
// saturating event counters and compares every DUT output against it.
module tb_pipe_stage_buf;

    localparam int          CNT_W = 4;
    localparam logic [31:0] NOP   = 32'h00000013;
    localparam int          CMAX  = 15;

    typedef struct {
        logic [31:0]  pc;
        logic [31:0]  ir;
        logic [15:0]  ctrl;
        logic [127:0] data;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_pc = 32'h0;
    logic [31:0]      in_ir = 32'h0;
    logic [15:0]      in_ctrl = 16'h0;
    logic [127:0]     in_data = 128'h0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_pc;
    logic [31:0]      out_ir;
    logic [15:0]      out_ctrl;
    logic [127:0]     out_data;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int    n_checks = 0;
    int    n_fail   = 0;
    beat_t sb_q[$];
    beat_t exp_b;
    int    stall_m = 0;
    int    flush_m = 0;

    pipe_stage_buf #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_ir(in_ir), .in_ctrl(in_ctrl), .in_data(in_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_ir(out_ir), .out_ctrl(out_ctrl), .out_data(out_data),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [31:0] pc);
        in_pc   = pc;
        in_ir   = $urandom;
        in_ctrl = 16'($urandom_range(1, 65535));
        in_data = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Asynchronous reset applied mid-cycle; outputs must change without a clock edge.
    task automatic do_reset();
        in_valid = 1'b0;
        flush    = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_ir", out_ir, NOP);
        check("rst_out_ctrl", out_ctrl, 16'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_data", out_data, 128'h0);
        check("rst_stall_cnt", stall_cnt, 4'd0);
        check("rst_flush_cnt", flush_cnt, 4'd0);
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Reference model + scoreboard: check state, then predict the coming edge.
    always @(negedge clk) begin
        int  sz;
        bit  ov_m;
        bit  ir_m;
        if (!rst) begin
            sb_q.delete();
            stall_m = 0;
            flush_m = 0;
            check("mon_rst_valid", out_valid, 1'b0);
            check("mon_rst_ready", in_ready, 1'b1);
        end else begin
            sz   = sb_q.size();
            ov_m = (sz > 0);
            ir_m = (sz < 2);
            check("out_valid", out_valid, ov_m);
            check("in_ready", in_ready, ir_m);
            check("stall_cnt", stall_cnt, stall_m);
            check("flush_cnt", flush_cnt, flush_m);
            if (!ov_m) begin
                check("bubble_ir", out_ir, NOP);
                check("bubble_ctrl", out_ctrl, 16'h0);
            end
            if (ov_m && !out_ready && stall_m < CMAX) stall_m++;
            if (flush) begin
                if (sz > 0 && flush_m < CMAX) flush_m++;
                sb_q.delete();
            end else begin
                if (ov_m && out_ready) begin
                    exp_b = sb_q.pop_front();
                    check("out_pc", out_pc, exp_b.pc);
                    check("out_ir", out_ir, exp_b.ir);
                    check("out_ctrl", out_ctrl, exp_b.ctrl);
                    check("out_data", out_data, exp_b.data);
                end
                if (in_valid && ir_m) begin
                    sb_q.push_back('{pc: in_pc, ir: in_ir, ctrl: in_ctrl, data: in_data});
                end
            end
        end
    end

    initial begin
        bit got;
        do_reset();

        // Streaming: back-to-back beats with one-cycle latency.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_beat(32'h0);
        step();
        check("stream_first_valid", out_valid, 1'b1);
        check("stream_first_pc", out_pc, 32'h0);
        set_beat(32'h4);
        step();
        check("stream_second_pc", out_pc, 32'h4);
        set_beat(32'h8);
        step();
        check("stream_third_pc", out_pc, 32'h8);
        in_valid = 1'b0;
        repeat (2) step();
        check("stream_stall_cnt", stall_cnt, 4'd0);

        // Backpressure: A and B held, C waits for in_ready.
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_beat(32'h100);
        step();
        set_beat(32'h104);
        step();
        check("bp_in_ready_low", in_ready, 1'b0);
        set_beat(32'h108);
        step();
        step();
        out_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (in_ready) got = 1'b1;
            step();
        end
        check("bp_c_accepted", got, 1'b1);
        in_valid = 1'b0;
        repeat (3) step();
        check("bp_stall_cnt", stall_cnt, 4'd3);

        // Flush while FULL with an incoming beat.
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_beat(32'h180);
        step();
        set_beat(32'h184);
        step();
        set_beat(32'h300);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", out_valid, 1'b0);
        check("flush_ir", out_ir, NOP);
        check("flush_ctrl", out_ctrl, 16'h0);
        check("flush_in_ready", in_ready, 1'b1);
        check("flush_cnt_one", flush_cnt, 4'd1);
        out_ready = 1'b1;
        repeat (3) step();

        // ONE with simultaneous in_fire and out_fire.
        do_reset();
        in_valid = 1'b1;
        set_beat(32'h200);
        step();
        out_ready = 1'b1;
        set_beat(32'h204);
        step();
        check("one_pc", out_pc, 32'h204);
        check("one_valid", out_valid, 1'b1);
        check("one_in_ready", in_ready, 1'b1);
        in_valid = 1'b0;
        repeat (2) step();

        // Stall counter saturation.
        do_reset();
        in_valid = 1'b1;
        set_beat(32'h400);
        step();
        in_valid = 1'b0;
        repeat (20) step();
        check("sat_stall_15", stall_cnt, 4'd15);
        repeat (3) step();
        check("sat_stall_hold", stall_cnt, 4'd15);

        // Asynchronous reset while FULL (checks inside do_reset).
        in_valid = 1'b1;
        set_beat(32'h500);
        step();
        do_reset();

        // Random traffic with occasional flushes.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            set_beat($urandom);
            step();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (5) step();
        check("drain_empty", out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline stage register with a valid/ready handshake and a two-entry skid buffer. It is the successor to the fixed ID/EX-style latches and is instantiated between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). On flush it turns held instructions into bubbles: IR becomes NOP and control is zeroed. It also counts stall and flush events for performance debug.

## Interface
Parameters:
- PC_W, 32, width of instruction address field
- IR_W, 32, width of instruction field
- CTRL_W, 16, width of control bundle (RegWrite, WR, MIO, ALUC, ...); all-zero means "no side effects"
- DATA_W, 128, width of data payload (operands, immediate, register addresses)
- NOP_IR, 32'h00000013, IR value driven for bubbles
- CNT_W, 16, width of each event counter

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept a beat
- in_pc / in_ir / in_ctrl / in_data  in  PC_W / IR_W / CTRL_W / DATA_W  upstream payload
- flush  in  1  synchronous kill of all held and incoming beats
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts beat
- out_pc / out_ir / out_ctrl / out_data  out  PC_W / IR_W / CTRL_W / DATA_W  payload of head entry
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
- flush_cnt  out  CNT_W  flush cycles that killed at least one valid entry, saturating

## Operation
- Storage: main entry (drives out_*), skid entry. State is encoded by {main_v, skid_v}: EMPTY, ONE, FULL.
- Signal definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = !skid_v, taken from a register. out_valid = main_v.
- EMPTY: in_fire loads main and goes to ONE. Otherwise main_v stays 0.
- ONE, with in_fire and out_fire together: main loads the input, state stays ONE.
- ONE, in_fire only: skid loads the input, state goes to FULL.
- ONE, out_fire only: go to EMPTY and the main entry becomes a bubble.
- FULL: in_ready=0. out_fire moves skid into main and goes to ONE. Otherwise hold.
- Bubble rule: whenever main_v becomes or stays 0, out_ir <= NOP_IR and out_ctrl <= 0. out_pc and out_data hold their last value. Invariant: out_valid=0 implies out_ctrl=0 and out_ir=NOP_IR.
- flush has highest priority over every transition. Both entries are invalidated and the state goes to EMPTY with a bubble in main.
- During flush, a beat with in_valid=1 and in_ready=1 is consumed and discarded; the upstream sees it as accepted.
- Beat order is strictly FIFO and no beat is duplicated.
- stall_cnt increments when out_valid & !out_ready. flush_cnt increments when flush & (main_v | skid_v). Both saturate at all-ones and never wrap.

## Timing
- rst=0 acts immediately, independent of clk. All outputs are valid while rst is held low and remain so until the first edge after rst=1. Reset values:
  - out_valid=0, in_ready=1
  - out_ir=NOP_IR, out_ctrl=0, out_pc=0, out_data=0
  - stall_cnt=0, flush_cnt=0
- Latency: one cycle from in_fire (EMPTY/ONE) to out_valid.
- Throughput: one beat per cycle sustained when out_ready=1.
- All outputs come from registers. There is no combinational path from out_ready to in_ready or from in_* to out_*.
- in_ready drops the cycle after the skid entry fills, so at most one extra beat is accepted after out_ready falls.
- Reset asserted mid-transfer discards all entries; no partial beat may appear after reset releases.

## Test plan
- Reset: drive rst low mid-stream while FULL -> asynchronously out_valid=0, in_ready=1, out_ir=0x00000013, out_ctrl=0, both counters 0.
- Streaming: out_ready=1, push pc 0x0, 0x4, 0x8 on consecutive cycles -> each appears one cycle later, back-to-back, stall_cnt stays 0.
- Backpressure: out_ready=0, push A (pc 0x100) and B (0x104) -> in_ready=0 after B, C (0x108) held by upstream. After 3 stalled cycles raise out_ready -> A, B, C in order, stall_cnt=3.
- Flush while FULL with in_valid=1: flush=1 for one cycle -> next cycle out_valid=0, out_ir=0x13, out_ctrl=0, in_ready=1, flush_cnt=1, flushed input never appears.
- ONE state with in_fire and out_fire together, pc 0x200 held and 0x204 pushed -> state stays ONE, out_pc=0x204 next cycle, in_ready stays 1.
- Saturation with CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 and stays at 15.
